// File: rtl/flag_pkg.sv
// Shared state encoding, mode codes and colour palettes for the chevron flag renderer.
package flag_pkg;

  localparam int unsigned COLOR_W  = 6;
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_HALF   = 240;

  typedef enum logic [1:0] {
    ST_STATIC = 2'd0,
    ST_REVEAL = 2'd1,
    ST_SCROLL = 2'd2,
    ST_HOLD   = 2'd3
  } flag_state_t;

  localparam logic [1:0] MODE_STATIC = 2'b00;
  localparam logic [1:0] MODE_REVEAL = 2'b01;
  localparam logic [1:0] MODE_SCROLL = 2'b10;

  // Colour constants, RRGGBB
  localparam logic [5:0] C_BLACK      = 6'b000000;
  localparam logic [5:0] C_WHITE      = 6'b111111;
  localparam logic [5:0] C_PINK       = 6'b110110;
  localparam logic [5:0] C_LIGHT_BLUE = 6'b011011;
  localparam logic [5:0] C_BROWN      = 6'b100100;
  localparam logic [5:0] C_GREY       = 6'b010101;
  localparam logic [5:0] C_MAGENTA    = 6'b110011;
  localparam logic [5:0] C_CYAN       = 6'b001111;
  localparam logic [5:0] C_SILVER     = 6'b101010;
  localparam logic [5:0] C_RED        = 6'b110000;
  localparam logic [5:0] C_ORANGE     = 6'b110100;
  localparam logic [5:0] C_YELLOW     = 6'b111100;
  localparam logic [5:0] C_GREEN      = 6'b001100;
  localparam logic [5:0] C_BLUE       = 6'b000011;
  localparam logic [5:0] C_PURPLE     = 6'b100011;
  localparam logic [5:0] C_CREAM      = 6'b111110;
  localparam logic [5:0] C_NAVY       = 6'b000001;

  // Chevron palette, 8 entries
  function automatic logic [5:0] chevron_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return C_WHITE;
      3'd1:    return C_PINK;
      3'd2:    return C_LIGHT_BLUE;
      3'd3:    return C_BROWN;
      3'd4:    return C_GREY;
      3'd5:    return C_MAGENTA;
      3'd6:    return C_CYAN;
      default: return C_SILVER;
    endcase
  endfunction

  // Background stripe palette, 8 entries
  function automatic logic [5:0] stripe_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return C_RED;
      3'd1:    return C_ORANGE;
      3'd2:    return C_YELLOW;
      3'd3:    return C_GREEN;
      3'd4:    return C_BLUE;
      3'd5:    return C_PURPLE;
      3'd6:    return C_CREAM;
      default: return C_NAVY;
    endcase
  endfunction

endpackage

// File: rtl/flag_rainbow_n.sv
// Horizontal background stripe selection: stripe floor(pix_y*N_STRIPE/480), purely combinational.
module flag_rainbow_n
  import flag_pkg::*;
#(
  parameter int unsigned N_STRIPE = 6
) (
  input  logic [9:0] pix_y,
  output logic [5:0] stripe_color_c
);

  localparam int unsigned PROD_W = 14;

  logic [2:0]        stripe_idx;
  logic [PROD_W-1:0] y_scaled;

  // Count boundaries crossed; pix_y*N >= 480*k is a constant multiply per boundary
  always_comb begin
    stripe_idx = 3'd0;
    y_scaled   = PROD_W'(pix_y) * PROD_W'(N_STRIPE);
    for (int unsigned k = 1; k < N_STRIPE; k++) begin
      if (y_scaled >= PROD_W'(V_ACTIVE * k)) stripe_idx = stripe_idx + 3'd1;
    end
    stripe_color_c = stripe_color(stripe_idx);
  end

endmodule

// File: rtl/flag_chevron_anim.sv
// Chevron flag renderer with static, left-to-right reveal and scrolling animations.
module flag_chevron_anim
  import flag_pkg::*;
#(
  parameter int unsigned N_CHEVRON = 5,
  parameter int unsigned BAND_W    = 60,
  parameter int unsigned N_STRIPE  = 6,
  parameter int unsigned SPEED     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       frame_start,
  input  logic [1:0] mode,
  output logic [5:0] color,
  output logic       busy
);

  localparam int unsigned POS_W   = 11;
  localparam int unsigned SPAN    = N_CHEVRON * BAND_W + H_ACTIVE;
  localparam int unsigned PHASE_W = 7;
  localparam int unsigned ROT_W   = 3;
  localparam int unsigned REV_W   = 10;

  flag_state_t         state;
  logic [PHASE_W-1:0]  phase;
  logic [ROT_W-1:0]    rot;
  logic [REV_W-1:0]    reveal;

  logic [PHASE_W:0]    phase_step;
  logic [REV_W:0]      reveal_step;
  logic [ROT_W-1:0]    rot_inc;

  logic [7:0]          ty;
  logic [POS_W-1:0]    sx_sum;
  logic [POS_W-1:0]    sx;
  logic                band_hit;
  logic [2:0]          band;
  logic [3:0]          pal_sum;
  logic [2:0]          pal_idx;
  logic [5:0]          stripe_color_c;
  logic [5:0]          pix_color_c;

  // Per-frame increments for the animation registers
  always_comb begin
    phase_step  = (PHASE_W+1)'(phase) + (PHASE_W+1)'(SPEED);
    reveal_step = (REV_W+1)'(reveal) + (REV_W+1)'(SPEED);
    rot_inc     = (rot == ROT_W'(N_CHEVRON - 1)) ? '0 : rot + ROT_W'(1);
  end

  // Animation FSM; advances only on frame_start so mid-frame mode changes are invisible
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_STATIC;
      phase  <= '0;
      rot    <= '0;
      reveal <= '0;
      busy   <= 1'b0;
    end else if (frame_start) begin
      case (mode)
        MODE_REVEAL: begin
          if (state == ST_REVEAL) begin
            if (reveal_step >= (REV_W+1)'(H_ACTIVE)) begin
              reveal <= REV_W'(H_ACTIVE);
              state  <= ST_HOLD;
              busy   <= 1'b0;
            end else begin
              reveal <= REV_W'(reveal_step);
              busy   <= 1'b1;
            end
          end else if (state == ST_HOLD) begin
            // Reveal is one-shot while mode stays at REVEAL; a different mode re-arms it
            busy <= 1'b0;
          end else begin
            state  <= ST_REVEAL;
            reveal <= '0;
            busy   <= 1'b1;
          end
        end
        MODE_SCROLL: begin
          if (state == ST_SCROLL) begin
            if (phase_step >= (PHASE_W+1)'(BAND_W)) begin
              phase <= PHASE_W'(phase_step - (PHASE_W+1)'(BAND_W));
              rot   <= rot_inc;
            end else begin
              phase <= PHASE_W'(phase_step);
            end
          end
          state <= ST_SCROLL;
          busy  <= 1'b0;
        end
        default: begin
          state  <= ST_STATIC;
          phase  <= '0;
          rot    <= '0;
          reveal <= '0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

  flag_rainbow_n #(
    .N_STRIPE(N_STRIPE)
  ) u_rainbow (
    .pix_y          (pix_y),
    .stripe_color_c (stripe_color_c)
  );

  // Pixel colour: fold rows about the centre, shift by phase, pick the lowest matching band
  always_comb begin
    ty = (pix_y < 10'(V_HALF)) ? 8'(pix_y) : 8'(10'(V_ACTIVE - 1) - pix_y);

    sx_sum = POS_W'(pix_x) + POS_W'(phase);
    sx     = (sx_sum >= POS_W'(SPAN)) ? sx_sum - POS_W'(SPAN) : sx_sum;

    band_hit = 1'b0;
    band     = 3'd0;
    for (int k = int'(N_CHEVRON) - 1; k >= 0; k--) begin
      if (sx < POS_W'(ty) + POS_W'((k + 1) * int'(BAND_W))) begin
        band_hit = 1'b1;
        band     = 3'(k);
      end
    end

    pal_sum = 4'(band) + 4'(rot);
    pal_idx = (pal_sum >= 4'(N_CHEVRON)) ? 3'(pal_sum - 4'(N_CHEVRON)) : 3'(pal_sum);

    pix_color_c = band_hit ? chevron_color(pal_idx) : stripe_color_c;
    if ((state == ST_REVEAL) && (pix_x >= reveal)) pix_color_c = C_BLACK;
  end

  // Registered colour output, one clock after the pixel coordinates
  always_ff @(posedge clk or posedge reset) begin
    if (reset) color <= C_BLACK;
    else       color <= pix_color_c;
  end

endmodule

// File: tb/tb_flag_chevron_anim.sv
// Directed bench for flag_chevron_anim with hand-computed vectors and a small reference model.
module tb_flag_chevron_anim;

  localparam int N_CHEVRON = 5;
  localparam int BAND_W    = 60;
  localparam int N_STRIPE  = 6;
  localparam int SPEED     = 4;

  localparam int M_STATIC = 0;
  localparam int M_REVEAL = 1;
  localparam int M_SCROLL = 2;
  localparam int M_HOLD   = 3;

  logic       clk;
  logic       reset;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       frame_start;
  logic [1:0] mode;
  logic [5:0] color;
  logic       busy;

  int n_cmp;
  int n_bad;

  int m_state;
  int m_phase;
  int m_rot;
  int m_reveal;

  flag_chevron_anim #(
    .N_CHEVRON(N_CHEVRON),
    .BAND_W   (BAND_W),
    .N_STRIPE (N_STRIPE),
    .SPEED    (SPEED)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .frame_start (frame_start),
    .mode        (mode),
    .color       (color),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] chev_ref(input int i);
    case (i)
      0: return 6'b111111;
      1: return 6'b110110;
      2: return 6'b011011;
      3: return 6'b100100;
      4: return 6'b010101;
      5: return 6'b110011;
      6: return 6'b001111;
      default: return 6'b101010;
    endcase
  endfunction

  function automatic logic [5:0] stripe_ref(input int i);
    case (i)
      0: return 6'b110000;
      1: return 6'b110100;
      2: return 6'b111100;
      3: return 6'b001100;
      4: return 6'b000011;
      5: return 6'b100011;
      6: return 6'b111110;
      default: return 6'b000001;
    endcase
  endfunction

  function automatic logic [5:0] ref_color(input int x, input int y, input int st,
                                           input int ph, input int rt, input int rv);
    int ty;
    int sx;
    logic found;
    logic [5:0] c;
    ty = (y < 240) ? y : 479 - y;
    sx = (x + ph) % (N_CHEVRON * BAND_W + 640);
    found = 1'b0;
    c = stripe_ref((y * N_STRIPE) / 480);
    for (int k = 0; k < N_CHEVRON; k++) begin
      if (!found && sx < ty + (k + 1) * BAND_W) begin
        found = 1'b1;
        c = chev_ref((k + rt) % N_CHEVRON);
      end
    end
    if (st == M_REVEAL && x >= rv) c = 6'b000000;
    return c;
  endfunction

  task automatic frame_pulse();
    @(negedge clk);
    frame_start = 1'b1;
    case (mode)
      2'b01: begin
        if (m_state == M_REVEAL) begin
          if (m_reveal + SPEED >= 640) begin
            m_reveal = 640;
            m_state  = M_HOLD;
          end else begin
            m_reveal = m_reveal + SPEED;
          end
        end else if (m_state != M_HOLD) begin
          m_state  = M_REVEAL;
          m_reveal = 0;
        end
      end
      2'b10: begin
        if (m_state == M_SCROLL) begin
          m_phase = m_phase + SPEED;
          if (m_phase >= BAND_W) begin
            m_phase = m_phase - BAND_W;
            m_rot   = (m_rot + 1) % N_CHEVRON;
          end
        end
        m_state = M_SCROLL;
      end
      default: begin
        m_state  = M_STATIC;
        m_phase  = 0;
        m_rot    = 0;
        m_reveal = 0;
      end
    endcase
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame_pulse();
  endtask

  // Drive a pixel and wait until its colour is registered
  task automatic show(input int x, input int y);
    @(negedge clk);
    pix_x = 10'(x);
    pix_y = 10'(y);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int xs[6];
    int ys[6];
    logic [5:0] ex[6];
    xs = '{0, 639, 0, 0, 300, 299};
    ys = '{0, 240, 479, 239, 0, 0};
    ex = '{6'b111111, 6'b001100, 6'b111111, 6'b111111, 6'b110000, 6'b010101};
    reset = 1'b1;
    pix_x = 10'd0;
    pix_y = 10'd0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (color !== 6'b000000) begin n_bad++; $display("FAIL reset_color got=%b exp=%b", color, 6'b000000); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      show(xs[i], ys[i]);
      n_cmp++;
      if (color !== ex[i]) begin
        n_bad++;
        $display("FAIL static_px(%0d,%0d) got=%b exp=%b", xs[i], ys[i], color, ex[i]);
      end
    end
  endtask

  task automatic test_reveal();
    mode = 2'b01;
    frame_pulse();
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL reveal_entry_busy got=%b exp=1", busy); end
    frames(10);
    show(39, 0);
    n_cmp++;
    if (color !== 6'b111111) begin n_bad++; $display("FAIL reveal40_x39 got=%b exp=%b", color, 6'b111111); end
    show(40, 0);
    n_cmp++;
    if (color !== 6'b000000) begin n_bad++; $display("FAIL reveal40_x40 got=%b exp=%b", color, 6'b000000); end
    frames(149);
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL reveal636_busy got=%b exp=1", busy); end
    show(635, 240);
    n_cmp++;
    if (color !== 6'b001100) begin n_bad++; $display("FAIL reveal636_x635 got=%b exp=%b", color, 6'b001100); end
    frames(1);
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL hold_busy got=%b exp=0", busy); end
    show(639, 240);
    n_cmp++;
    if (color !== 6'b001100) begin n_bad++; $display("FAIL hold_x639 got=%b exp=%b", color, 6'b001100); end
    frames(2);
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL hold_no_restart_busy got=%b exp=0", busy); end
    show(300, 0);
    n_cmp++;
    if (color !== 6'b110000) begin n_bad++; $display("FAIL hold_x300 got=%b exp=%b", color, 6'b110000); end
  endtask

  task automatic test_scroll();
    mode = 2'b10;
    frame_pulse();
    frames(14);
    show(4, 0);
    n_cmp++;
    if (color !== 6'b110110) begin n_bad++; $display("FAIL scroll56_x4 got=%b exp=%b", color, 6'b110110); end
    show(3, 0);
    n_cmp++;
    if (color !== 6'b111111) begin n_bad++; $display("FAIL scroll56_x3 got=%b exp=%b", color, 6'b111111); end
    frames(1);
    show(0, 0);
    n_cmp++;
    if (color !== 6'b110110) begin n_bad++; $display("FAIL wrap_rot1_x0 got=%b exp=%b", color, 6'b110110); end
    show(60, 0);
    n_cmp++;
    if (color !== 6'b011011) begin n_bad++; $display("FAIL wrap_rot1_x60 got=%b exp=%b", color, 6'b011011); end
    show(299, 0);
    n_cmp++;
    if (color !== 6'b111111) begin n_bad++; $display("FAIL wrap_rot1_x299 got=%b exp=%b", color, 6'b111111); end
    frames(60);
    show(0, 0);
    n_cmp++;
    if (color !== 6'b111111) begin n_bad++; $display("FAIL rot_wrap0_x0 got=%b exp=%b", color, 6'b111111); end
    show(60, 0);
    n_cmp++;
    if (color !== 6'b110110) begin n_bad++; $display("FAIL rot_wrap0_x60 got=%b exp=%b", color, 6'b110110); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL scroll_busy got=%b exp=0", busy); end
  endtask

  task automatic test_mode_glitch();
    frames(1);
    show(56, 0);
    n_cmp++;
    if (color !== 6'b110110) begin n_bad++; $display("FAIL pre_glitch_x56 got=%b exp=%b", color, 6'b110110); end
    @(negedge clk); mode = 2'b00;
    @(negedge clk); mode = 2'b10;
    @(negedge clk); mode = 2'b00;
    show(56, 0);
    n_cmp++;
    if (color !== 6'b110110) begin n_bad++; $display("FAIL post_glitch_x56 got=%b exp=%b", color, 6'b110110); end
    show(55, 0);
    n_cmp++;
    if (color !== 6'b111111) begin n_bad++; $display("FAIL post_glitch_x55 got=%b exp=%b", color, 6'b111111); end
    mode = 2'b10;
    frames(1);
    show(52, 0);
    n_cmp++;
    if (color !== 6'b110110) begin n_bad++; $display("FAIL glitch_next_x52 got=%b exp=%b", color, 6'b110110); end
    show(51, 0);
    n_cmp++;
    if (color !== 6'b111111) begin n_bad++; $display("FAIL glitch_next_x51 got=%b exp=%b", color, 6'b111111); end
  endtask

  task automatic test_reset_mid_reveal();
    mode = 2'b01;
    frame_pulse();
    frames(50);
    show(200, 0);
    n_cmp++;
    if (color !== 6'b000000) begin n_bad++; $display("FAIL reveal200_x200 got=%b exp=%b", color, 6'b000000); end
    show(199, 0);
    n_cmp++;
    if (color !== 6'b100100) begin n_bad++; $display("FAIL reveal200_x199 got=%b exp=%b", color, 6'b100100); end
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL reveal200_busy got=%b exp=1", busy); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++;
    if (color !== 6'b000000) begin n_bad++; $display("FAIL async_reset_color got=%b exp=%b", color, 6'b000000); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL async_reset_busy got=%b exp=0", busy); end
    m_state  = M_STATIC;
    m_phase  = 0;
    m_rot    = 0;
    m_reveal = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    show(300, 0);
    n_cmp++;
    if (color !== 6'b110000) begin n_bad++; $display("FAIL post_reset_x300 got=%b exp=%b", color, 6'b110000); end
    show(0, 0);
    n_cmp++;
    if (color !== 6'b111111) begin n_bad++; $display("FAIL post_reset_x0 got=%b exp=%b", color, 6'b111111); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
  endtask

  // Back-to-back pixel stream; each colour is checked exactly one clock after its pixel
  task automatic stream_check(input string tag, input int n);
    logic [5:0] exp_prev;
    int px;
    int py;
    exp_prev = 6'b000000;
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_cmp++;
        if (color !== exp_prev) begin
          n_bad++;
          $display("FAIL %s_px(%0d,%0d) got=%b exp=%b", tag, px, py, color, exp_prev);
        end
      end
      case (i)
        0: begin px = 0;   py = 0;   end
        1: begin px = 639; py = 0;   end
        2: begin px = 0;   py = 479; end
        3: begin px = 639; py = 479; end
        4: begin px = 320; py = 240; end
        default: begin
          px = int'($urandom_range(0, 639));
          py = int'($urandom_range(0, 479));
        end
      endcase
      pix_x = 10'(px);
      pix_y = 10'(py);
      exp_prev = ref_color(px, py, m_state, m_phase, m_rot, m_reveal);
    end
  endtask

  task automatic test_sweep_static();
    mode = 2'b00;
    frame_pulse();
    stream_check("static_sweep", 600);
  endtask

  task automatic test_sweep_scroll();
    mode = 2'b10;
    frame_pulse();
    frames(22);
    stream_check("scroll_sweep", 300);
    mode = 2'b11;
    frame_pulse();
    stream_check("reserved_sweep", 100);
  endtask

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    m_state     = M_STATIC;
    m_phase     = 0;
    m_rot       = 0;
    m_reveal    = 0;
    reset       = 1'b1;
    frame_start = 1'b0;
    mode        = 2'b00;
    pix_x       = 10'd0;
    pix_y       = 10'd0;

    test_reset();
    test_reveal();
    test_scroll();
    test_mode_glitch();
    test_reset_mid_reveal();
    test_sweep_static();
    test_sweep_scroll();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
